// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame widths, arbiter state encoding and
// the ADXL345 register map used by spi_arbiter and spi_control.
package spi_pkg;

    localparam int SPI_TX_W = 16;
    localparam int SPI_RX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_RELEASE   = 2'd2
    } arb_state_t;

    localparam logic SPI_MODE_READ  = 1'b1;
    localparam logic SPI_MODE_WRITE = 1'b0;

    localparam logic [5:0] ADXL_DEVID       = 6'h00;
    localparam logic [5:0] ADXL_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADXL_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADXL_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADXL_DATAX0      = 6'h32;
    localparam logic [5:0] ADXL_DATAX1      = 6'h33;

    // Frame layout: {rw, multi_byte, addr[5:0], wdata[7:0]}
    function automatic logic [SPI_TX_W-1:0] adxl_frame(
        input logic       rw,
        input logic [5:0] addr,
        input logic [7:0] wdata
    );
        return {rw, 1'b0, addr, wdata};
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin selector: first requester after ptr,
// wrapping, with one-hot grant and binary index.
module spi_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        logic [PTR_W-1:0] c;
        c     = '0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!valid && req[c]) begin
                valid  = 1'b1;
                gnt[c] = 1'b1;
                idx    = c;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_serdes frame engine between
// NUM_REQ requesters, with a done-watchdog against a stuck serdes.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TX_W           = SPI_TX_W,
    parameter int RX_W           = SPI_RX_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    spi_clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*TX_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [RX_W-1:0]         rsp_data,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic                    err_sticky,
    input  logic                    err_clr,
    output logic                    serdes_start,
    output logic [TX_W-1:0]         serdes_data_tx,
    input  logic                    serdes_done,
    input  logic [RX_W-1:0]         serdes_data_rx
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    arb_state_t         state;
    logic [PTR_W-1:0]   ptr;
    logic [TMR_W-1:0]   timer;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    spi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_any)
    );

    always_ff @(posedge spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            ptr            <= PTR_W'(NUM_REQ - 1);
            timer          <= '0;
            gnt            <= '0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            rsp_timeout    <= 1'b0;
            busy           <= 1'b0;
            err_sticky     <= 1'b0;
            serdes_start   <= 1'b0;
            serdes_data_tx <= '0;
        end else begin
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_timeout <= 1'b0;
            // A watchdog set below overrides this clear
            if (err_clr)
                err_sticky <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt            <= pick_gnt;
                        serdes_data_tx <= req_data[pick_idx*TX_W +: TX_W];
                        serdes_start   <= 1'b1;
                        ptr            <= pick_idx;
                        timer          <= '0;
                        busy           <= 1'b1;
                        state          <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (serdes_done) begin
                        rsp_data     <= serdes_data_rx;
                        rsp_valid    <= NUM_REQ'(1) << ptr;
                        serdes_start <= 1'b0;
                        timer        <= '0;
                        state        <= ST_RELEASE;
                    end else if (timer == TMR_LAST) begin
                        rsp_data     <= '0;
                        rsp_valid    <= NUM_REQ'(1) << ptr;
                        rsp_timeout  <= 1'b1;
                        err_sticky   <= 1'b1;
                        serdes_start <= 1'b0;
                        timer        <= '0;
                        state        <= ST_RELEASE;
                    end else if (timer != TMR_MAX) begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!serdes_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (timer == TMR_LAST) begin
                        err_sticky <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (timer != TMR_MAX) begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed and randomized bench for spi_arbiter with a behavioural
// serdes model and a transaction-level round-robin reference.
module tb_spi_arbiter;

    localparam int N   = 2;
    localparam int TXW = 16;
    localparam int RXW = 8;
    localparam int TO  = 64;

    logic           spi_clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*TXW-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [RXW-1:0] rsp_data;
    logic           rsp_timeout;
    logic           busy;
    logic           err_sticky;
    logic           err_clr = 1'b0;
    logic           serdes_start;
    logic [TXW-1:0] serdes_data_tx;
    logic           serdes_done;
    logic [RXW-1:0] serdes_data_rx = '0;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned done_delay = 18;
    bit          never_done = 1'b0;
    bit          stuck_done = 1'b0;
    int unsigned sd_cnt;

    logic [N-1:0]   pend = '0;
    logic [TXW-1:0] mdata [N];
    int             mptr = N - 1;
    int             want;
    int             cyc;
    int             cnt;
    logic [TXW-1:0] cap;

    spi_arbiter #(
        .NUM_REQ        (N),
        .TX_W           (TXW),
        .RX_W           (RXW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .spi_clk        (spi_clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_data       (req_data),
        .gnt            (gnt),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_timeout    (rsp_timeout),
        .busy           (busy),
        .err_sticky     (err_sticky),
        .err_clr        (err_clr),
        .serdes_start   (serdes_start),
        .serdes_data_tx (serdes_data_tx),
        .serdes_done    (serdes_done),
        .serdes_data_rx (serdes_data_rx)
    );

    always #5 spi_clk = ~spi_clk;

    // Serdes model: done rises done_delay cycles after start rises
    always @(posedge spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            serdes_done <= 1'b0;
            sd_cnt      <= 0;
        end else if (serdes_start) begin
            sd_cnt <= sd_cnt + 1;
            if (!never_done && sd_cnt + 1 >= done_delay)
                serdes_done <= 1'b1;
        end else begin
            sd_cnt <= 0;
            if (!stuck_done)
                serdes_done <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req = pend;
        for (int i = 0; i < N; i++)
            req_data[i*TXW +: TXW] = mdata[i];
    endtask

    function automatic int rr_next(input int p, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(p + k) % N])
                return (p + k) % N;
        return -1;
    endfunction

    task automatic wait_gnt(input int lim, output int c);
        c = 0;
        while (gnt == '0 && c < lim) begin
            @(negedge spi_clk);
            c++;
        end
        chk("gnt_arrived", 32'(gnt != '0), 32'd1);
    endtask

    task automatic wait_rsp(input int lim, output int c);
        c = 0;
        while (rsp_valid == '0 && c < lim) begin
            @(negedge spi_clk);
            c++;
        end
        chk("rsp_arrived", 32'(rsp_valid != '0), 32'd1);
    endtask

    initial begin
        #800_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++)
            mdata[i] = '0;

        repeat (3) @(negedge spi_clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(serdes_start), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        chk("rst_tx", 32'(serdes_data_tx), 32'd0);
        reset_n = 1'b1;
        @(negedge spi_clk);

        // Single request
        done_delay     = 18;
        serdes_data_rx = 8'h5A;
        pend           = 2'b01;
        mdata[0]       = 16'hB200;
        drive();
        wait_gnt(20, cyc);
        chk("single_lat", 32'(cyc), 32'd1);
        chk("single_gnt", 32'(gnt), 32'd1);
        chk("single_tx", 32'(serdes_data_tx), 32'hB200);
        chk("single_start", 32'(serdes_start), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        mptr = 0;
        wait_rsp(100, cyc);
        chk("single_rsp_lat", 32'(cyc), 32'd19);
        chk("single_rsp", 32'(rsp_valid), 32'd1);
        chk("single_data", 32'(rsp_data), 32'h5A);
        chk("single_to", 32'(rsp_timeout), 32'd0);
        pend = '0;
        drive();

        // Contention with both requests held
        pend     = 2'b11;
        mdata[0] = 16'h2C09;
        mdata[1] = 16'hB300;
        drive();
        for (int f = 0; f < 4; f++) begin
            done_delay     = 3 + f;
            serdes_data_rx = 8'(8'h30 + f);
            want = rr_next(mptr, pend);
            wait_gnt(40, cyc);
            chk("cont_gnt", 32'(gnt), 32'(1) << want);
            chk("cont_tx", 32'(serdes_data_tx), 32'(mdata[want]));
            mptr = want;
            wait_rsp(100, cyc);
            chk("cont_rsp", 32'(rsp_valid), 32'(1) << want);
            chk("cont_data", 32'(rsp_data), 32'(8'h30 + f));
        end

        // Stale request: requester 1 drops after its response
        done_delay = 4;
        want = rr_next(mptr, pend);
        wait_gnt(40, cyc);
        chk("stale_gnt1", 32'(gnt), 32'(1) << want);
        mptr = want;
        wait_rsp(100, cyc);
        pend[1] = 1'b0;
        drive();
        wait_gnt(40, cyc);
        chk("stale_gnt0", 32'(gnt), 32'd1);
        mptr = 0;
        wait_rsp(100, cyc);
        chk("stale_rsp0", 32'(rsp_valid), 32'd1);
        pend = '0;
        drive();
        cnt = 0;
        repeat (30) begin
            @(negedge spi_clk);
            if (gnt != '0)
                cnt++;
        end
        chk("stale_no_regrant", 32'(cnt), 32'd0);

        // Watchdog in WAIT_DONE
        never_done     = 1'b1;
        serdes_data_rx = 8'hA5;
        pend           = 2'b01;
        mdata[0]       = 16'hB200;
        drive();
        wait_gnt(20, cyc);
        chk("wd_gnt", 32'(gnt), 32'd1);
        wait_rsp(200, cyc);
        chk("wd_lat", 32'(cyc), 32'(TO));
        chk("wd_rsp", 32'(rsp_valid), 32'd1);
        chk("wd_to", 32'(rsp_timeout), 32'd1);
        chk("wd_data", 32'(rsp_data), 32'd0);
        chk("wd_start", 32'(serdes_start), 32'd0);
        chk("wd_err", 32'(err_sticky), 32'd1);
        pend = '0;
        drive();
        never_done = 1'b0;
        repeat (3) @(negedge spi_clk);
        chk("wd_idle", 32'(busy), 32'd0);
        chk("wd_err_hold", 32'(err_sticky), 32'd1);
        err_clr = 1'b1;
        @(negedge spi_clk);
        err_clr = 1'b0;
        chk("wd_err_clr", 32'(err_sticky), 32'd0);

        // Stuck done in RELEASE, err_clr held to test set priority
        stuck_done     = 1'b1;
        done_delay     = 5;
        serdes_data_rx = 8'hC3;
        pend           = 2'b01;
        drive();
        wait_gnt(20, cyc);
        chk("stuck_gnt", 32'(gnt), 32'd1);
        wait_rsp(100, cyc);
        chk("stuck_rsp_lat", 32'(cyc), 32'd6);
        chk("stuck_data", 32'(rsp_data), 32'hC3);
        chk("stuck_err0", 32'(err_sticky), 32'd0);
        pend = '0;
        drive();
        err_clr = 1'b1;
        cyc = 0;
        while (busy && cyc < 200) begin
            @(negedge spi_clk);
            cyc++;
        end
        chk("stuck_release_lat", 32'(cyc), 32'(TO));
        chk("stuck_err_prio", 32'(err_sticky), 32'd1);
        err_clr    = 1'b0;
        stuck_done = 1'b0;
        repeat (3) @(negedge spi_clk);
        done_delay     = 7;
        serdes_data_rx = 8'h11;
        pend           = 2'b10;
        mdata[1]       = 16'h8F00;
        drive();
        want = rr_next(mptr, pend);
        wait_gnt(20, cyc);
        chk("stuck_next_gnt", 32'(gnt), 32'(1) << want);
        chk("stuck_next_tx", 32'(serdes_data_tx), 32'h8F00);
        mptr = want;
        wait_rsp(100, cyc);
        chk("stuck_next_data", 32'(rsp_data), 32'h11);
        pend = '0;
        drive();

        // Reset mid-frame
        never_done = 1'b1;
        pend       = 2'b10;
        mdata[1]   = 16'h2D08;
        drive();
        wait_gnt(20, cyc);
        chk("rstmid_gnt", 32'(gnt), 32'd2);
        repeat (5) @(negedge spi_clk);
        reset_n = 1'b0;
        #1;
        chk("rstmid_start", 32'(serdes_start), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_gnt0", 32'(gnt), 32'd0);
        never_done     = 1'b0;
        done_delay     = 4;
        serdes_data_rx = 8'hE7;
        pend           = 2'b11;
        mdata[0]       = 16'($urandom);
        drive();
        @(negedge spi_clk);
        reset_n = 1'b1;
        mptr    = N - 1;
        wait_gnt(20, cyc);
        chk("rstmid_first_lat", 32'(cyc), 32'd1);
        chk("rstmid_first", 32'(gnt), 32'd1);
        chk("rstmid_tx", 32'(serdes_data_tx), 32'(mdata[0]));
        mptr = 0;
        wait_rsp(100, cyc);
        chk("rstmid_data", 32'(rsp_data), 32'hE7);
        pend[0] = 1'b0;
        drive();

        // Randomized frames against the transaction-level model
        for (int f = 0; f < 40; f++) begin
            for (int j = 0; j < N; j++)
                if (!pend[j] && $urandom_range(0, 1) == 1) begin
                    pend[j]  = 1'b1;
                    mdata[j] = 16'($urandom);
                end
            if (pend == '0) begin
                want        = $urandom_range(0, N - 1);
                pend[want]  = 1'b1;
                mdata[want] = 16'($urandom);
            end
            done_delay     = $urandom_range(1, 25);
            serdes_data_rx = 8'($urandom);
            drive();
            want = rr_next(mptr, pend);
            wait_gnt(200, cyc);
            chk("rnd_gnt", 32'(gnt), 32'(1) << want);
            chk("rnd_tx", 32'(serdes_data_tx), 32'(mdata[want]));
            chk("rnd_busy", 32'(busy), 32'd1);
            cap         = mdata[want];
            mptr        = want;
            mdata[want] = 16'($urandom);
            for (int j = 0; j < N; j++)
                if (!pend[j] && $urandom_range(0, 1) == 1) begin
                    pend[j]  = 1'b1;
                    mdata[j] = 16'($urandom);
                end
            drive();
            @(negedge spi_clk);
            chk("rnd_tx_hold", 32'(serdes_data_tx), 32'(cap));
            chk("rnd_start", 32'(serdes_start), 32'd1);
            wait_rsp(100, cyc);
            chk("rnd_rsp_lat", 32'(cyc + 1), 32'(done_delay + 1));
            chk("rnd_rsp", 32'(rsp_valid), 32'(1) << want);
            chk("rnd_data", 32'(rsp_data), 32'(serdes_data_rx));
            chk("rnd_to", 32'(rsp_timeout), 32'd0);
            pend[want] = 1'b0;
            drive();
        end

        repeat (5) @(negedge spi_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
